uart_cmd_controller: RTL

Sequencer between the UART instruction decoder and the two UART channel cores (A = 0, B = 1). It accepts one decoded UART command at a time over a valid/ready handshake and carries it out against the addressed channel:
- waits for the transmitter, or for received data with a timeout;
- owns the per-channel baud divisors and RX holding registers;
- returns a 32-bit result with a one-cycle done pulse that the core uses to release its stall.

---
 rtl/uart_ctrl_pkg.sv | 33 +++
 rtl/uart_rx_hold.sv | 39 +++
 rtl/uart_cmd_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared opcodes, sequencer states and result constants for the UART command controller.
package uart_ctrl_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_TELL    = 3'd1;
  localparam logic [2:0] OP_READ    = 3'd2;
  localparam logic [2:0] OP_WRITE   = 3'd3;
  localparam logic [2:0] OP_BAUDSET = 3'd4;
  localparam logic [2:0] OP_DEBUG1  = 3'd5;
  localparam logic [2:0] OP_DEBUG2  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_WAIT_RX = 3'd3,
    S_DONE    = 3'd4
  } ctrl_state_e;

  localparam logic [7:0]  TELL_STATUS  = 8'h00;
  localparam logic [7:0]  TELL_BAUD    = 8'h01;
  localparam logic [31:0] RESULT_EMPTY = 32'hFFFF_FFFF;

  // A zero divisor would stall the baud generator, so it is forced to 1.
  function automatic logic [31:0] clamp_divisor(input logic [31:0] i_div);
    if (i_div == 32'd0) begin
      return 32'd1;
    end else begin
      return i_div;
    end
  endfunction

endpackage

// File: rtl/uart_rx_hold.sv
// Single-byte receive holding register with full flag and sticky overrun.
module uart_rx_hold (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  input  logic       i_consume,
  input  logic       i_clear_overrun,
  output logic [7:0] o_byte,
  output logic       o_full,
  output logic       o_overrun
);

  logic [7:0] r_byte;
  logic       r_full;
  logic       r_overrun;

  // A new byte always wins; a fresh overrun outranks a same-cycle clear so no loss is hidden.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte    <= 8'h00;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_valid) begin
        r_byte <= i_byte;
        r_full <= 1'b1;
      end else if (i_consume) begin
        r_full <= 1'b0;
      end
      r_overrun <= (r_overrun & ~i_clear_overrun) | (i_valid & r_full & ~i_consume);
    end
  end

  assign o_byte    = r_byte;
  assign o_full    = r_full;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_cmd_controller.sv
// Sequences one decoded UART command at a time against channel A or B and
// returns a 32-bit result with a one-cycle done pulse.
module uart_cmd_controller
  import uart_ctrl_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIVISOR = 32'd434,
  parameter int unsigned TIMEOUT_UNIT    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_instr,
  input  logic        cmd_channel,
  input  logic [7:0]  cmd_code,
  input  logic [31:0] cmd_data,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  tx_start,
  output logic [7:0]  tx_byte,
  input  logic [1:0]  tx_busy,
  input  logic [1:0]  rx_valid,
  input  logic [15:0] rx_byte,
  output logic [63:0] baud_div
);

  ctrl_state_e      r_state, w_next;
  logic [2:0]       r_instr;
  logic             r_ch;
  logic [7:0]       r_code;
  logic [31:0]      r_data;
  logic [7:0]       r_tx_byte;
  logic             r_tx_sent;
  logic [31:0]      r_tmo;
  logic             r_done;
  logic [31:0]      r_result;
  logic [1:0][31:0] r_baud;
  logic [1:0][15:0] r_tx_cnt;
  logic [1:0][15:0] r_rx_cnt;

  logic [31:0]      w_res;
  logic             w_load_res, w_fire, w_consume_sel, w_clr_sel;
  logic             w_baud_we, w_tmo_load, w_tmo_dec, w_set_sent;
  logic [1:0]       w_tx_start, w_consume, w_clr_ov;
  logic [1:0][7:0]  w_hold_byte;
  logic [1:0]       w_rx_full, w_overrun;

  for (genvar g = 0; g < 2; g++) begin : g_hold
    uart_rx_hold u_hold (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_valid         (rx_valid[g]),
      .i_byte          (rx_byte[g*8 +: 8]),
      .i_consume       (w_consume[g]),
      .i_clear_overrun (w_clr_ov[g]),
      .o_byte          (w_hold_byte[g]),
      .o_full          (w_rx_full[g]),
      .o_overrun       (w_overrun[g])
    );
  end

  // Next-state and per-state actions.
  always_comb begin
    w_next        = r_state;
    w_res         = 32'd0;
    w_load_res    = 1'b0;
    w_fire        = 1'b0;
    w_consume_sel = 1'b0;
    w_clr_sel     = 1'b0;
    w_baud_we     = 1'b0;
    w_tmo_load    = 1'b0;
    w_tmo_dec     = 1'b0;
    w_set_sent    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC: begin
        w_load_res = 1'b1;
        w_next     = S_DONE;
        case (r_instr)
          OP_TELL: begin
            case (r_code)
              TELL_STATUS: begin
                w_res     = {29'd0, w_overrun[r_ch], tx_busy[r_ch], w_rx_full[r_ch]};
                w_clr_sel = 1'b1;
              end
              TELL_BAUD: w_res = r_baud[r_ch];
              default:   w_res = 32'd0;
            endcase
          end
          OP_READ: begin
            if (w_rx_full[r_ch]) begin
              w_res         = {24'd0, w_hold_byte[r_ch]};
              w_consume_sel = 1'b1;
            end else if (r_code == 8'd0) begin
              w_res = RESULT_EMPTY;
            end else begin
              w_load_res = 1'b0;
              w_tmo_load = 1'b1;
              w_next     = S_WAIT_RX;
            end
          end
          OP_WRITE: begin
            if (!tx_busy[r_ch]) begin
              w_fire = 1'b1;
            end else begin
              w_load_res = 1'b0;
              w_next     = S_WAIT_TX;
            end
          end
          OP_BAUDSET: w_baud_we = 1'b1;
          OP_DEBUG1:  w_res = {16'd0, r_tx_cnt[r_ch]};
          OP_DEBUG2:  w_res = {16'd0, r_rx_cnt[r_ch]};
          default:    w_res = 32'd0;
        endcase
      end
      // After a delayed strobe, allow one cycle for the transmitter to raise busy.
      S_WAIT_TX: begin
        if (r_tx_sent) begin
          w_load_res = 1'b1;
          w_next     = S_DONE;
        end else if (!tx_busy[r_ch]) begin
          w_fire     = 1'b1;
          w_set_sent = 1'b1;
        end else begin
          w_next = S_WAIT_TX;
        end
      end
      S_WAIT_RX: begin
        if (w_rx_full[r_ch]) begin
          w_res         = {24'd0, w_hold_byte[r_ch]};
          w_consume_sel = 1'b1;
          w_load_res    = 1'b1;
          w_next        = S_DONE;
        end else if (rx_valid[r_ch]) begin
          w_next = S_WAIT_RX;
        end else if (r_tmo == 32'd0) begin
          w_res      = RESULT_EMPTY;
          w_load_res = 1'b1;
          w_next     = S_DONE;
        end else begin
          w_tmo_dec = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Steer per-channel strobes; reset suppresses any transmit strobe in flight.
  always_comb begin
    w_tx_start = 2'b00;
    w_consume  = 2'b00;
    w_clr_ov   = 2'b00;
    if (w_fire && !rst) begin
      w_tx_start[r_ch] = 1'b1;
    end else begin
      w_tx_start = 2'b00;
    end
    w_consume[r_ch] = w_consume_sel;
    w_clr_ov[r_ch]  = w_clr_sel;
  end

  // Sequencer state, latched command and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_instr   <= OP_NOP;
      r_ch      <= 1'b0;
      r_code    <= 8'h00;
      r_data    <= 32'd0;
      r_tx_byte <= 8'h00;
      r_tx_sent <= 1'b0;
      r_tmo     <= 32'd0;
      r_done    <= 1'b0;
      r_result  <= 32'd0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      if (w_load_res) r_result <= w_res;
      if (r_state == S_IDLE && cmd_valid) begin
        r_instr   <= cmd_instr;
        r_ch      <= cmd_channel;
        r_code    <= cmd_code;
        r_data    <= cmd_data;
        r_tx_sent <= 1'b0;
        if (cmd_instr == OP_WRITE) r_tx_byte <= cmd_data[7:0];
      end
      if (w_set_sent) r_tx_sent <= 1'b1;
      if (w_tmo_load) begin
        r_tmo <= 32'(r_code) * TIMEOUT_UNIT - 32'd1;
      end else if (w_tmo_dec) begin
        r_tmo <= r_tmo - 32'd1;
      end
    end
  end

  // Per-channel divisors and activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud   <= {DEFAULT_DIVISOR, DEFAULT_DIVISOR};
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_baud_we) r_baud[r_ch] <= clamp_divisor(r_data);
      if (w_fire) r_tx_cnt[r_ch] <= r_tx_cnt[r_ch] + 16'd1;
      if (w_consume_sel) r_rx_cnt[r_ch] <= r_rx_cnt[r_ch] + 16'd1;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign tx_start  = w_tx_start;
  assign tx_byte   = r_tx_byte;
  assign baud_div  = r_baud;

endmodule
